// File: rtl/gf2m_pkg.sv
// Shared constants and types for the digit-serial GF(2^M) arithmetic unit:
// operation encodings, controller states and common reduction polynomials.
package gf2m_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_SQR = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Low terms of x^128 + x^7 + x^2 + x + 1 and of the AES field x^8 + x^4 + x^3 + x + 1.
    localparam logic [127:0] P128 = 128'h87;
    localparam logic [7:0]   AES8 = 8'h1B;

endpackage

// File: rtl/gf2m_alu_digit_if.sv
// Start/busy/done operation bus between the point-arithmetic controller (master)
// and the field ALU (slave).
interface gf2m_alu_digit_if #(
    parameter int M = 128
);
    logic         start;
    logic [1:0]   op;
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic         busy;
    logic         done;
    logic [M-1:0] result;
    logic         err;

    modport master (
        output start, op, a, b,
        input  busy, done, result, err
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, err
    );
endinterface

// File: rtl/gf2m_digit_step.sv
// One MSB-first digit step: acc*x^D + A*bd, reduced mod x^M + POLY in one fold.
// Valid because deg(POLY) <= M-D keeps h*POLY below x^M.
module gf2m_digit_step #(
    parameter int           M    = 128,
    parameter int           D    = 8,
    parameter logic [M-1:0] POLY = 'h87
) (
    input  logic [M-1:0] i_acc,
    input  logic [M-1:0] i_a,
    input  logic [D-1:0] i_bd,
    output logic [M-1:0] o_acc
);
    logic [D:0][M+D-1:0] w_pp;
    logic [D:0][M-1:0]   w_rd;
    logic [D-1:0]        w_h;
    logic [M+D-1:0]      w_a_ext;

    assign w_a_ext = {{D{1'b0}}, i_a};
    assign w_pp[0] = {i_acc, {D{1'b0}}};

    // Unreduced (acc << D) xor carry-less A*bd; both overflow into the same top D bits.
    for (genvar gi = 0; gi < D; gi++) begin : g_pp
        assign w_pp[gi+1] = w_pp[gi] ^ ({(M+D){i_bd[gi]}} & (w_a_ext << gi));
    end

    assign w_h     = w_pp[D][M+D-1:M];
    assign w_rd[0] = w_pp[D][M-1:0];

    for (genvar gi = 0; gi < D; gi++) begin : g_rd
        assign w_rd[gi+1] = w_rd[gi] ^ ({M{w_h[gi]}} & (POLY << gi));
    end

    assign o_acc = w_rd[D];
endmodule

// File: rtl/gf2m_alu_digit.sv
// GF(2^M) add / digit-serial multiply / square unit with a start/busy/done handshake.
// Squaring reuses the multiplier with B = A.
module gf2m_alu_digit
    import gf2m_pkg::*;
#(
    parameter int           M    = 128,
    parameter int           D    = 8,
    parameter logic [M-1:0] POLY = 'h87
) (
    input  logic          clk,
    input  logic          rst,
    gf2m_alu_digit_if.slave bus
);
    localparam int NDIG = M / D;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(NDIG - 1);

    if ((D < 1) || (M % D != 0) || (D > M / 2)) begin : g_bad_digit
        $error("gf2m_alu_digit: D must divide M and satisfy 1 <= D <= M/2");
    end
    if ((POLY >> (M - D + 1)) != '0) begin : g_bad_poly
        $error("gf2m_alu_digit: POLY degree exceeds M-D, single-pass reduction invalid");
    end

    state_t        r_state;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic [M-1:0]  r_result;
    logic [M-1:0]  r_acc;
    logic [M-1:0]  r_a;
    logic [M-1:0]  r_b;
    logic [CW-1:0] r_cnt;

    logic [D-1:0]  w_bd;
    logic [M-1:0]  w_acc_next;

    assign w_bd = r_b[M-1 -: D];

    gf2m_digit_step #(
        .M    (M),
        .D    (D),
        .POLY (POLY)
    ) u_step (
        .i_acc (r_acc),
        .i_a   (r_a),
        .i_bd  (w_bd),
        .o_acc (w_acc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_result <= '0;
            r_acc    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_a   <= bus.a;
                        r_b   <= (bus.op == OP_SQR) ? bus.a : bus.b;
                        r_acc <= '0;
                        r_cnt <= CNT_LOAD;
                        r_err <= 1'b0;
                        case (bus.op)
                            OP_ADD: begin
                                r_result <= bus.a ^ bus.b;
                                r_done   <= 1'b1;
                            end
                            OP_MUL, OP_SQR: begin
                                r_state <= ST_MUL;
                                r_busy  <= 1'b1;
                            end
                            default: begin
                                r_err  <= 1'b1;
                                r_done <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_MUL: begin
                    r_acc <= w_acc_next;
                    r_b   <= r_b << D;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == '0) begin
                        r_state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    r_result <= r_acc;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.err    = r_err;
    assign bus.result = r_result;
endmodule

// File: tb/tb_gf2m_alu_digit.sv
// Directed bench for gf2m_alu_digit: 128-bit default field plus two 8-bit AES-field
// instances (D=1 and D=4); expected values are hand-derived or from a bitwise model.
module tb_gf2m_alu_digit;
    import gf2m_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gf2m_alu_digit_if #(.M(128)) bus ();
    gf2m_alu_digit_if #(.M(8))   bus1 ();
    gf2m_alu_digit_if #(.M(8))   bus4 ();

    gf2m_alu_digit #(.M(128), .D(8), .POLY(P128)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
    gf2m_alu_digit #(.M(8), .D(1), .POLY(AES8)) dut8_d1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );
    gf2m_alu_digit #(.M(8), .D(4), .POLY(AES8)) dut8_d4 (
        .clk (clk), .rst (rst), .bus (bus4)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference GF(2^128) multiply, LSB-first shift-and-add with x^128 = x^7+x^2+x+1.
    function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
        logic [127:0] r;
        logic [127:0] v;
        logic         c;
        r = '0;
        v = x;
        for (int i = 0; i < 128; i++) begin
            if (y[i]) r = r ^ v;
            c = v[127];
            v = v << 1;
            if (c) v = v ^ 128'h87;
        end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Issue one op on the 128-bit DUT and wait (bounded) for done; n = edges after accept.
    task automatic do_op(input logic [1:0] op, input logic [127:0] a, input logic [127:0] b,
                         output logic [127:0] res, output int n, output logic e);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("done_timeout", 128'(bus.done), 128'd1);
        res = bus.result;
        e   = bus.err;
        $display("op=%0d a=%h b=%h -> result=%h err=%0b edges=%0d", op, a, b, res, e, n);
    endtask

    initial begin
        logic [127:0] res;
        logic [127:0] ra;
        logic [127:0] rb;
        logic         e;
        int           n;
        int           n1;
        int           n4;
        int           done_cnt;
        logic [7:0]   res1;
        logic [7:0]   res4;

        rst = 1'b1;
        bus.start = 1'b0;  bus.op = OP_ADD;  bus.a = '0;  bus.b = '0;
        bus1.start = 1'b0; bus1.op = OP_ADD; bus1.a = '0; bus1.b = '0;
        bus4.start = 1'b0; bus4.op = OP_ADD; bus4.a = '0; bus4.b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",   128'(bus.busy), 128'd0);
        chk("rst_done",   128'(bus.done), 128'd0);
        chk("rst_err",    128'(bus.err),  128'd0);
        chk("rst_result", bus.result,     128'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Addition
        do_op(OP_ADD, {16{8'hF0}}, {16{8'hFF}}, res, n, e);
        chk("add_result",  res,        {16{8'h0F}});
        chk("add_latency", 128'(n),    128'd0);
        chk("add_err",     128'(e),    128'd0);

        // x^127 * x = x^128 = 0x87
        do_op(OP_MUL, 128'd1 << 127, 128'h2, res, n, e);
        chk("mul_x128",    res,     128'h87);
        chk("mul_latency", 128'(n), 128'd17);
        @(posedge clk); #1;
        chk("done_single_pulse", 128'(bus.done), 128'd0);

        // Multiplicative identity
        for (int i = 0; i < 100; i++) begin
            ra = rnd128();
            do_op(OP_MUL, ra, 128'h1, res, n, e);
            chk("mul_by_one", res, ra);
        end

        // (x^64)^2 = x^128 = 0x87
        do_op(OP_SQR, 128'd1 << 64, 128'hDEAD, res, n, e);
        chk("sqr_x64",     res,     128'h87);
        chk("sqr_latency", 128'(n), 128'd17);

        for (int i = 0; i < 5; i++) begin
            ra = rnd128();
            do_op(OP_SQR, ra, rnd128(), res, n, e);
            chk("sqr_rand", res, gf_mul(ra, ra));
        end
        for (int i = 0; i < 5; i++) begin
            ra = rnd128();
            rb = rnd128();
            do_op(OP_MUL, ra, rb, res, n, e);
            chk("mul_rand", res, gf_mul(ra, rb));
        end

        // AES field: 0x57 * 0x83 = 0xC1, D=1 (9 edges) and D=4 (3 edges)
        bus1.start = 1'b1; bus1.op = OP_MUL; bus1.a = 8'h57; bus1.b = 8'h83;
        bus4.start = 1'b1; bus4.op = OP_MUL; bus4.a = 8'h57; bus4.b = 8'h83;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        bus4.start = 1'b0;
        n1 = -1; n4 = -1; res1 = '0; res4 = '0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (bus1.done === 1'b1 && n1 < 0) begin n1 = k; res1 = bus1.result; end
            if (bus4.done === 1'b1 && n4 < 0) begin n4 = k; res4 = bus4.result; end
        end
        $display("m8 d1: result=%h edges=%0d | m8 d4: result=%h edges=%0d", res1, n1, res4, n4);
        chk("m8_d1_result",  128'(res1), 128'hC1);
        chk("m8_d1_latency", 128'(n1),   128'd9);
        chk("m8_d4_result",  128'(res4), 128'hC1);
        chk("m8_d4_latency", 128'(n4),   128'd3);

        // Start held high while busy must be ignored; a start in the done cycle is accepted.
        bus.start = 1'b1; bus.op = OP_MUL; bus.a = 128'd1 << 127; bus.b = 128'h2;
        @(posedge clk); #1;
        bus.a = rnd128();
        bus.b = rnd128();
        n = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        $display("held-start mult: result=%h edges=%0d", bus.result, n);
        chk("held_start_result",  bus.result, 128'h87);
        chk("held_start_latency", 128'(n),    128'd17);
        bus.op = OP_ADD; bus.a = 128'h1; bus.b = 128'h2;
        @(posedge clk); #1;
        bus.start = 1'b0;
        $display("add in done cycle: result=%h done=%0b", bus.result, bus.done);
        chk("b2b_done",   128'(bus.done), 128'd1);
        chk("b2b_result", bus.result,     128'h3);
        chk("b2b_busy",   128'(bus.busy), 128'd0);

        // Illegal opcode keeps the previous result
        do_op(OP_ILL, 128'hAAAA, 128'h5555, res, n, e);
        chk("ill_err",     128'(e),    128'd1);
        chk("ill_result",  res,        128'h3);
        chk("ill_latency", 128'(n),    128'd0);
        @(posedge clk); #1;
        chk("ill_done_pulse", 128'(bus.done), 128'd0);
        chk("ill_err_held",   128'(bus.err),  128'd1);
        do_op(OP_ADD, 128'h5, 128'h6, res, n, e);
        chk("err_cleared", 128'(e), 128'd0);
        chk("add_after_ill", res, 128'h3);

        // Reset in the middle of a multiplication
        bus.start = 1'b1; bus.op = OP_MUL; bus.a = rnd128(); bus.b = rnd128();
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        $display("reset mid-mult: busy=%0b done=%0b result=%h", bus.busy, bus.done, bus.result);
        chk("midrst_busy",   128'(bus.busy), 128'd0);
        chk("midrst_done",   128'(bus.done), 128'd0);
        chk("midrst_result", bus.result,     128'd0);
        done_cnt = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) done_cnt++;
        end
        chk("midrst_no_done", 128'(done_cnt), 128'd0);
        do_op(OP_ADD, 128'hA, 128'h5, res, n, e);
        chk("post_rst_add",         res,     128'hF);
        chk("post_rst_add_latency", 128'(n), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
